// File: rtl/vid_seq_pkg.sv
// Shared types and defaults for the BT.656-to-Avalon-ST read-side sequencer and formatter.
package vid_seq_pkg;

    localparam int unsigned DEF_LINES_PER_FIELD = 288;
    localparam int unsigned DEF_FIFO_LINES      = 5;
    localparam int unsigned CREDIT_W            = 3;

    typedef enum logic [1:0] {
        CMD_CTRL  = 2'd0,
        CMD_LINE  = 2'd1,
        CMD_FLUSH = 2'd2
    } cmd_type_e;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_CTRL_ISSUE  = 4'd1,
        ST_CTRL_WAIT   = 4'd2,
        ST_CREDIT_WAIT = 4'd3,
        ST_LINE_ISSUE  = 4'd4,
        ST_LINE_WAIT   = 4'd5,
        ST_NEXT        = 4'd6,
        ST_FLUSH_ISSUE = 4'd7,
        ST_FLUSH_WAIT  = 4'd8
    } state_e;

endpackage

// File: rtl/line_credit_counter.sv
// Counts complete lines held in the line FIFO; saturates at capacity and flags overflow.
module line_credit_counter
    import vid_seq_pkg::*;
#(
    parameter int unsigned FIFO_LINES = DEF_FIFO_LINES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                clear_i,
    output logic [CREDIT_W-1:0] count_o,
    output logic                overflow_o
);

    localparam logic [CREDIT_W-1:0] MAX_CNT = CREDIT_W'(FIFO_LINES);

    logic [CREDIT_W-1:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    // A write and a read in the same cycle cancel out; clear wins over both.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == MAX_CNT) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CREDIT_W'(1);
            end
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CREDIT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/field_sequencer.sv
// Read-side field sequencer: one CTRL per field, one LINE per available FIFO line,
// FLUSH on truncated fields, handshaked to the packet formatter.
module field_sequencer
    import vid_seq_pkg::*;
#(
    parameter int unsigned LINES_PER_FIELD = DEF_LINES_PER_FIELD,
    parameter int unsigned FIFO_LINES      = DEF_FIFO_LINES,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                field_start,
    input  logic                field_id,
    input  logic                line_written,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [1:0]          cmd_type,
    output logic                cmd_field,
    output logic                cmd_last,
    input  logic                op_done,
    output logic [CREDIT_W-1:0] lines_avail,
    output logic                overflow,
    output logic [CNT_W-1:0]    short_fields,
    output logic [CNT_W-1:0]    fields_sent
);

    localparam int unsigned IDX_W = (LINES_PER_FIELD > 1) ? $clog2(LINES_PER_FIELD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES_PER_FIELD - 1);

    state_e           state_q;
    cmd_type_e        cmd_type_q;
    logic             cmd_valid_q, cmd_field_q, cmd_last_q;
    logic             cur_field_q, pend_valid_q, pend_id_q;
    logic [IDX_W-1:0] line_idx_q;
    logic [CNT_W-1:0] short_q, sent_q;

    logic line_accept_c, credit_clear_c, credit_avail_c;

    assign line_accept_c  = (state_q == ST_LINE_ISSUE) && cmd_valid_q && cmd_ready;
    assign credit_clear_c = (state_q == ST_FLUSH_WAIT) && op_done;
    assign credit_avail_c = (lines_avail != '0);

    line_credit_counter #(
        .FIFO_LINES (FIFO_LINES)
    ) u_credit (
        .clock      (clock),
        .reset      (reset),
        .inc_i      (line_written),
        .dec_i      (line_accept_c),
        .clear_i    (credit_clear_c),
        .count_o    (lines_avail),
        .overflow_o (overflow)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_valid_q  <= 1'b0;
            cmd_type_q   <= CMD_CTRL;
            cmd_field_q  <= 1'b0;
            cmd_last_q   <= 1'b0;
            cur_field_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= 1'b0;
            line_idx_q   <= '0;
            short_q      <= '0;
            sent_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pend_valid_q <= 1'b0;
                    if (enable && field_start && !field_id) begin
                        cur_field_q <= 1'b0;
                        state_q     <= ST_CTRL_ISSUE;
                    end
                end
                ST_CTRL_ISSUE: begin
                    if (!cmd_valid_q) begin
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= CMD_CTRL;
                        cmd_field_q <= cur_field_q;
                        cmd_last_q  <= 1'b0;
                    end else if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_CTRL_WAIT;
                    end
                end
                ST_CTRL_WAIT: begin
                    if (op_done) begin
                        line_idx_q <= '0;
                        state_q    <= credit_avail_c ? ST_LINE_ISSUE : ST_CREDIT_WAIT;
                    end
                end
                ST_CREDIT_WAIT: begin
                    // A new field while starved means the current one was cut short.
                    if (field_start) begin
                        state_q <= ST_FLUSH_ISSUE;
                    end else if (credit_avail_c) begin
                        state_q <= ST_LINE_ISSUE;
                    end
                end
                ST_LINE_ISSUE: begin
                    if (!cmd_valid_q) begin
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= CMD_LINE;
                        cmd_field_q <= cur_field_q;
                        cmd_last_q  <= (line_idx_q == LAST_IDX);
                    end else if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_LINE_WAIT;
                    end
                end
                ST_LINE_WAIT: begin
                    if (op_done) begin
                        if (cmd_last_q) begin
                            sent_q  <= sent_q + CNT_W'(1);
                            state_q <= ST_NEXT;
                        end else begin
                            line_idx_q <= line_idx_q + IDX_W'(1);
                            state_q    <= credit_avail_c ? ST_LINE_ISSUE : ST_CREDIT_WAIT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (!enable) begin
                        pend_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (pend_valid_q) begin
                        cur_field_q  <= pend_id_q;
                        pend_valid_q <= 1'b0;
                        state_q      <= ST_CTRL_ISSUE;
                    end
                end
                ST_FLUSH_ISSUE: begin
                    if (!cmd_valid_q) begin
                        cmd_valid_q <= 1'b1;
                        cmd_type_q  <= CMD_FLUSH;
                        cmd_field_q <= cur_field_q;
                        cmd_last_q  <= 1'b0;
                    end else if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_FLUSH_WAIT;
                    end
                end
                ST_FLUSH_WAIT: begin
                    if (op_done) begin
                        short_q      <= short_q + CNT_W'(1);
                        cur_field_q  <= pend_id_q;
                        pend_valid_q <= 1'b0;
                        state_q      <= ST_CTRL_ISSUE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Latest field_start outside IDLE always lands in the pending slot.
            if ((state_q != ST_IDLE) && field_start) begin
                pend_valid_q <= 1'b1;
                pend_id_q    <= field_id;
            end
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd_type     = cmd_type_q;
    assign cmd_field    = cmd_field_q;
    assign cmd_last     = cmd_last_q;
    assign short_fields = short_q;
    assign fields_sent  = sent_q;

endmodule

// File: tb/tb_field_sequencer.sv
// Self-checking bench for field_sequencer: formatter model with a command scoreboard,
// a credit-counter vector table and hand-written multi-cycle sequences.
module tb_field_sequencer;

    logic        clock = 1'b0;
    logic        reset, enable, field_start, field_id, line_written;
    logic        cmd_valid, cmd_ready, cmd_field, cmd_last, op_done, overflow;
    logic [1:0]  cmd_type;
    logic [2:0]  lines_avail;
    logic [15:0] short_fields, fields_sent;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] t;
        logic       f;
        logic       l;
    } cmd_t;

    typedef struct {
        logic lw;
        int   avail;
        logic ovf;
    } vec_t;

    cmd_t exp_q[$];
    logic fmt_en   = 1'b0;
    int   done_lat = 1;
    int   line_cnt = 0;
    int   last_cnt = 0;

    field_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .field_start  (field_start),
        .field_id     (field_id),
        .line_written (line_written),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_field    (cmd_field),
        .cmd_last     (cmd_last),
        .op_done      (op_done),
        .lines_avail  (lines_avail),
        .overflow     (overflow),
        .short_fields (short_fields),
        .fields_sent  (fields_sent)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void push_cmd(input int t, input logic f, input logic l);
        cmd_t c;
        c.t = 2'(t);
        c.f = f;
        c.l = l;
        exp_q.push_back(c);
    endfunction

    // Formatter model: accepts a pending command, compares it against the scoreboard,
    // and pulses op_done done_lat cycles after the accept edge.
    initial begin
        int   done_cnt;
        cmd_t got, e;
        done_cnt  = 0;
        cmd_ready = 1'b0;
        op_done   = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            op_done = 1'b0;
            if (cmd_ready) begin
                cmd_ready = 1'b0;
                done_cnt  = done_lat;
            end else if (fmt_en && cmd_valid) begin
                cmd_ready = 1'b1;
                got = {cmd_type, cmd_field, cmd_last};
                if (cmd_type == 2'd1) line_cnt++;
                if (cmd_last) last_cnt++;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_cmd", int'(got), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_cmd", int'(got), int'(e));
                end
            end
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) op_done = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic id);
        field_id    = id;
        field_start = 1'b1;
        @(negedge clock);
        field_start = 1'b0;
    endtask

    // Writes lines while the FIFO holds fewer than 3, until total reaches target.
    task automatic feed_lines(input int start, input int target, input string name);
        int written = start;
        int budget  = 20000;
        while (written < target && budget > 0) begin
            @(negedge clock);
            budget--;
            if (lines_avail < 3) begin
                line_written = 1'b1;
                written++;
            end else begin
                line_written = 1'b0;
            end
        end
        @(negedge clock);
        line_written = 1'b0;
        chk(name, written, target);
    endtask

    initial begin
        vec_t vecs[7];
        int   budget, base, seen;
        logic hit;

        vecs[0] = '{1'b1, 1, 1'b0};
        vecs[1] = '{1'b1, 2, 1'b0};
        vecs[2] = '{1'b1, 3, 1'b0};
        vecs[3] = '{1'b1, 4, 1'b0};
        vecs[4] = '{1'b1, 5, 1'b0};
        vecs[5] = '{1'b1, 5, 1'b1};
        vecs[6] = '{1'b0, 5, 1'b1};

        enable = 1'b0; field_start = 1'b0; field_id = 1'b0; line_written = 1'b0;
        @(negedge clock);
        do_reset();

        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_cmd_type", int'(cmd_type), 0);
        chk("rst_lines_avail", int'(lines_avail), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_counters", int'(short_fields) + int'(fields_sent), 0);

        // Credit table: six writes without reads saturate at 5 and set overflow.
        for (int i = 0; i < 7; i++) begin
            line_written = vecs[i].lw;
            @(negedge clock);
            chk($sformatf("credit_vec%0d_avail", i), int'(lines_avail), vecs[i].avail);
            chk($sformatf("credit_vec%0d_ovf", i), int'(overflow), int'(vecs[i].ovf));
        end
        line_written = 1'b0;
        do_reset();
        chk("rst_clears_overflow", int'(overflow), 0);

        // Field 1 alone never starts sequencing.
        enable = 1'b1;
        pulse_start(1'b1);
        hit = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (cmd_valid) hit = 1'b1;
        end
        chk("f1_first_ignored", int'(hit), 0);

        // F0 start: CTRL appears exactly two cycles later and holds while stalled.
        push_cmd(0, 1'b0, 1'b0);
        field_id = 1'b0;
        field_start = 1'b1;
        @(negedge clock);
        field_start = 1'b0;
        chk("ctrl_lat_cycle1", int'(cmd_valid), 0);
        @(negedge clock);
        chk("ctrl_lat_cycle2", int'({cmd_valid, cmd_type, cmd_field}), int'({1'b1, 2'd0, 1'b0}));
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("stall_hold%0d", i), int'({cmd_valid, cmd_type, cmd_field, cmd_last}),
                int'({1'b1, 2'd0, 1'b0, 1'b0}));
        end

        // Full field of 288 lines.
        for (int i = 0; i < 288; i++) push_cmd(1, 1'b0, (i == 287));
        fmt_en = 1'b1;
        feed_lines(0, 288, "field0_written");
        budget = 5000;
        while (fields_sent != 16'd1 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        chk("field0_fields_sent", int'(fields_sent), 1);
        chk("field0_line_cmds", line_cnt, 288);
        chk("field0_last_cnt", last_cnt, 1);
        chk("field0_no_overflow", int'(overflow), 0);
        chk("field0_credit_empty", int'(lines_avail), 0);
        chk("field0_sb_drained", exp_q.size(), 0);

        // Next field (id 1): prefill to 5, then a write coinciding with the first LINE accept.
        fmt_en = 1'b0;
        push_cmd(0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) push_cmd(1, 1'b1, 1'b0);
        push_cmd(2, 1'b1, 1'b0);
        push_cmd(0, 1'b0, 1'b0);
        pulse_start(1'b1);
        repeat (5) begin
            line_written = 1'b1;
            @(negedge clock);
        end
        line_written = 1'b0;
        @(negedge clock);
        chk("prefill_avail", int'(lines_avail), 5);
        base = line_cnt;
        fmt_en = 1'b1;
        budget = 50;
        seen = 0;
        while (seen == 0 && budget > 0) begin
            @(negedge clock);
            budget--;
            if (cmd_valid && cmd_type == 2'd1) seen = 1;
        end
        chk("first_line_seen", seen, 1);
        line_written = 1'b1;
        @(negedge clock);
        line_written = 1'b0;
        chk("simul_wr_rd_avail", int'(lines_avail), 5);
        chk("simul_wr_rd_ovf", int'(overflow), 0);

        // Truncate after 100 lines while starved.
        feed_lines(6, 100, "field1_written");
        budget = 3000;
        while ((line_cnt - base) < 100 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        chk("field1_lines_read", line_cnt - base, 100);
        repeat (4) @(negedge clock);
        fmt_en = 1'b0;
        pulse_start(1'b0);
        budget = 20;
        seen = 0;
        while (seen == 0 && budget > 0) begin
            @(negedge clock);
            budget--;
            if (cmd_valid) seen = 1;
        end
        chk("flush_issued", int'({seen[0], cmd_type, cmd_field}), int'({1'b1, 2'd2, 1'b1}));
        repeat (2) begin
            line_written = 1'b1;
            @(negedge clock);
        end
        line_written = 1'b0;
        @(negedge clock);
        chk("flush_pending_avail", int'(lines_avail), 2);
        fmt_en = 1'b1;
        budget = 50;
        while (short_fields != 16'd1 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        chk("short_fields", int'(short_fields), 1);
        chk("flush_clears_credit", int'(lines_avail), 0);
        chk("fields_sent_unchanged", int'(fields_sent), 1);
        repeat (8) @(negedge clock);
        chk("trunc_sb_drained", exp_q.size(), 0);

        // Reset while a LINE is outstanding.
        done_lat = 20;
        push_cmd(1, 1'b0, 1'b0);
        base = line_cnt;
        line_written = 1'b1;
        @(negedge clock);
        line_written = 1'b0;
        budget = 20;
        while (line_cnt == base && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        chk("line_before_reset", line_cnt - base, 1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_cmd", int'({cmd_valid, cmd_type, cmd_field, cmd_last}), 0);
        chk("midrst_avail_ovf", int'({lines_avail, overflow}), 0);
        chk("midrst_short", int'(short_fields), 0);
        chk("midrst_sent", int'(fields_sent), 0);
        reset = 1'b0;
        done_lat = 1;
        hit = 1'b0;
        repeat (25) begin
            @(negedge clock);
            if (cmd_valid) hit = 1'b1;
        end
        chk("post_reset_idle", int'(hit), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
